// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core.
// Contents:
//   OPCODE_MSB/OPCODE_LSB - opcode field bounds in an instruction word
//   HALT_OP               - opcode that stops fetch
//   NOP_INSTR             - bubble encoding (sll $0,$0,0)
//   if_id_t               - IF/ID pipeline bundle {instruction, pc_plus4, valid}
package pipeline_pkg;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;

    localparam logic [5:0]  HALT_OP   = 6'h3f;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline register holding one if_id_t bundle.
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - synchronous active-high reset, loads the bubble
//   flush_i  - synchronous flush, loads the bubble (overrides enable_i)
//   enable_i - 1 = load d_i, 0 = hold
//   d_i      - next bundle
//   q_o      - registered bundle
module if_id_register
    import pipeline_pkg::*;
#(
    parameter logic [31:0] BubbleInstr = NOP_INSTR
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   flush_i,
    input  logic   enable_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t bubble;
    if_id_t bundle_d;
    if_id_t bundle_q;

    always_comb begin
        bubble             = '0;
        bubble.instruction = BubbleInstr;
    end

    always_comb begin
        bundle_d = bundle_q;
        if (flush_i) begin
            bundle_d = bubble;
        end else if (enable_i) begin
            bundle_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bundle_q <= bubble;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign q_o = bundle_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem address, IF/ID register, halt
// tracking and a saturating fetched-instruction counter.
// Ports:
//   clk, reset                      - clock and synchronous active-high reset
//   pc_enable, ifid_enable          - hazard-unit stall controls (0 = hold)
//   redirect_valid/redirect_target  - downstream branch/jump redirect + flush
//   imem_addr / imem_data           - combinational instruction memory port
//   D_instruction/D_pc_plus4/D_valid - IF/ID outputs to decode
//   halted                          - sticky halt-in-decode flag
//   fetch_count                     - instructions latched into IF/ID
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR,
    parameter logic [5:0]  HALT_OP   = pipeline_pkg::HALT_OP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_enable,
    input  logic        ifid_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] D_instruction,
    output logic [31:0] D_pc_plus4,
    output logic        D_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    import pipeline_pkg::*;

    logic [31:0] pc_d, pc_q;
    logic        halted_d, halted_q;
    logic [31:0] count_d, count_q;
    logic [31:0] pc_plus4;
    logic        ifid_load;
    logic        is_halt;
    if_id_t      ifid_in;
    if_id_t      ifid_out;

    // Redirect targets are word aligned; the two low bits are dropped.
    logic        unused_target_lsbs;
    assign unused_target_lsbs = ^redirect_target[1:0];

    assign pc_plus4  = pc_q + 32'd4;
    assign is_halt   = (imem_data[OPCODE_MSB:OPCODE_LSB] == HALT_OP);
    // A latched halt freezes IF/ID so the halt instruction stays in decode.
    assign ifid_load = ifid_enable && !halted_q;

    always_comb begin
        ifid_in.instruction = imem_data;
        ifid_in.pc_plus4    = pc_plus4;
        ifid_in.valid       = 1'b1;
    end

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_target[31:2], 2'b00};
            // Anything fetched so far is wrong-path, including a halt.
            halted_d = 1'b0;
        end else if (!halted_q) begin
            if (pc_enable) begin
                pc_d = pc_plus4;
            end
            if (ifid_enable) begin
                if (count_q != 32'hFFFF_FFFF) begin
                    count_d = count_q + 32'd1;
                end
                if (is_halt) begin
                    halted_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            count_q  <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    if_id_register #(
        .BubbleInstr(NOP_INSTR)
    ) u_if_id (
        .clk_i   (clk),
        .reset_i (reset),
        .flush_i (redirect_valid),
        .enable_i(ifid_load),
        .d_i     (ifid_in),
        .q_o     (ifid_out)
    );

    assign imem_addr     = pc_q;
    assign D_instruction = ifid_out.instruction;
    assign D_pc_plus4    = ifid_out.pc_plus4;
    assign D_valid       = ifid_out.valid;
    assign halted        = halted_q;
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, run, stall, redirect, halt, wrap,
// reset during stall. imem_data is driven per step to the word at the
// current PC.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        pc_enable;
    logic        ifid_enable;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] D_instruction;
    logic [31:0] D_pc_plus4;
    logic        D_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .pc_enable      (pc_enable),
        .ifid_enable    (ifid_enable),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .D_instruction  (D_instruction),
        .D_pc_plus4     (D_pc_plus4),
        .D_valid        (D_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] pc4, input logic valid, input logic hlt,
                           input logic [31:0] cnt);
        chk({tag, ".pc"}, imem_addr, pc);
        chk({tag, ".instr"}, D_instruction, instr);
        chk({tag, ".pc4"}, D_pc_plus4, pc4);
        chk({tag, ".valid"}, {31'd0, D_valid}, {31'd0, valid});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, hlt});
        chk({tag, ".count"}, fetch_count, cnt);
    endtask

    initial begin
        reset           = 1'b1;
        pc_enable       = 1'b1;
        ifid_enable     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        imem_data       = 32'h2001_0005;
        tick();
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        // Run: two instructions.
        reset     = 1'b0;
        imem_data = 32'h2001_0005;
        tick();
        chk_all("run1", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 1'b0, 32'd1);
        imem_data = 32'h2002_0007;
        tick();
        chk_all("run2", 32'h8, 32'h2002_0007, 32'h8, 1'b1, 1'b0, 32'd2);

        // Load-use stall for one cycle at PC=8.
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
        imem_data   = 32'h2003_0009;
        tick();
        chk_all("stall", 32'h8, 32'h2002_0007, 32'h8, 1'b1, 1'b0, 32'd2);
        pc_enable   = 1'b1;
        ifid_enable = 1'b1;
        tick();
        chk_all("resume", 32'hC, 32'h2003_0009, 32'hC, 1'b1, 1'b0, 32'd3);

        // Redirect while stalled; low target bits dropped.
        pc_enable       = 1'b0;
        ifid_enable     = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0043;
        imem_data       = 32'h8C00_0000;
        tick();
        chk_all("redir", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'd3);

        // Halt fetched at 0x40.
        redirect_valid = 1'b0;
        pc_enable      = 1'b1;
        ifid_enable    = 1'b1;
        imem_data      = 32'hFC00_0000;
        tick();
        chk_all("halt", 32'h44, 32'hFC00_0000, 32'h44, 1'b1, 1'b1, 32'd4);
        imem_data = 32'h2001_0005;
        repeat (10) tick();
        chk_all("halt_hold", 32'h44, 32'hFC00_0000, 32'h44, 1'b1, 1'b1, 32'd4);

        // Redirect clears the halt.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        tick();
        chk_all("unhalt", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 32'd4);

        // Wrap at the top of the address space.
        redirect_target = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pre.pc", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        imem_data      = 32'h2004_000B;
        tick();
        chk_all("wrap", 32'h0, 32'h2004_000B, 32'h0, 1'b1, 1'b0, 32'd5);

        // pc_enable=1 with ifid_enable=0: PC moves, IF/ID holds, no X.
        ifid_enable = 1'b0;
        imem_data   = 32'h2005_000D;
        tick();
        chk("mixed.pc", imem_addr, 32'h4);
        chk("mixed.noX", {31'd0, $isunknown({D_instruction, D_pc_plus4, D_valid, fetch_count})},
            32'd0);
        chk("mixed.instr", D_instruction, 32'h2004_000B);

        // Halt opcode with ifid_enable=0 is not latched.
        pc_enable = 1'b0;
        imem_data = 32'hFC00_0000;
        tick();
        chk("halt_gated.halted", {31'd0, halted}, 32'd0);
        chk("halt_gated.count", fetch_count, 32'd5);

        // Redirect on the same edge as a halt fetch cancels it.
        pc_enable       = 1'b1;
        ifid_enable     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        tick();
        chk_all("halt_vs_redir", 32'h200, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);

        // Advance once, then reset during a stall.
        redirect_valid = 1'b0;
        imem_data      = 32'h2006_0001;
        tick();
        chk_all("pre_reset", 32'h204, 32'h2006_0001, 32'h204, 1'b1, 1'b0, 32'd6);
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
        reset       = 1'b1;
        tick();
        chk_all("reset_stall", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: holds the PC, drives the instruction-memory address, and owns the IF/ID pipeline register that feeds decode.
- Consumes the PC-enable and IF/ID-enable stall outputs of the decode-stage hazard detection unit, plus the branch/jump redirect from the later stages.
- Inserts NOP bubbles on redirect, freezes on halt, and keeps a fetched-instruction counter for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding placed in IF/ID on reset or flush (sll $0,$0,0).
- HALT_OP, 6'h3f, opcode (bits [31:26]) that denotes halt.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_enable  in  1  from hazard unit; 0 = hold PC this cycle.
- ifid_enable  in  1  from hazard unit; 0 = hold IF/ID this cycle.
- redirect_valid  in  1  taken branch/jump resolved downstream; flush and redirect.
- redirect_target  in  32  new PC when redirect_valid=1.
- imem_addr  out  32  instruction-memory address, combinationally equal to PC.
- imem_data  in  32  instruction word, combinational read of imem_addr, same cycle.
- D_instruction  out  32  IF/ID instruction to decode.
- D_pc_plus4  out  32  IF/ID PC+4 of that instruction.
- D_valid  out  1  IF/ID holds a real fetched instruction (0 = bubble).
- halted  out  1  sticky: halt instruction latched into IF/ID.
- fetch_count  out  32  number of instructions latched into IF/ID since reset.

Behaviour:
- Reset (reset=1 at edge): PC=RESET_PC; D_instruction=NOP_INSTR; D_pc_plus4=0; D_valid=0; halted=0; fetch_count=0. Reset overrides all other inputs and aborts any in-progress stall.
- Priority per edge: reset > redirect > halted-hold > stall > advance.
- Redirect (redirect_valid=1): PC <= {redirect_target[31:2],2'b00}, with the low bits forced to zero. IF/ID <= NOP_INSTR / D_pc_plus4=0 / D_valid=0. halted <= 0, because a wrong-path halt is cancelled. fetch_count is unchanged. Redirect wins over pc_enable=0 and ifid_enable=0, since the redirecting instruction is older than the stalled one.
- Halted hold (halted=1, no redirect): PC and IF/ID are frozen regardless of the enables, so the halt stays in decode. fetch_count is frozen.
- Stall:
  - pc_enable=0: PC holds.
  - ifid_enable=0: IF/ID holds all three fields.
  - The enables are independent. With pc_enable=1 and ifid_enable=0, PC still advances; the hazard unit never drives this combination, and the bench only checks that no X is produced.
- Advance (no redirect, not halted):
  - If pc_enable=1: PC <= PC+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - If ifid_enable=1: D_instruction <= imem_data; D_pc_plus4 <= PC+4; D_valid <= 1; fetch_count increments, saturating at 32'hFFFF_FFFF.
  - If imem_data[31:26]==HALT_OP and ifid_enable=1, halted <= 1 on the same edge.
- Latency: an instruction at address A appears on D_instruction one edge after PC==A with both enables high.
- imem_addr is purely combinational from the PC register; there are no other combinational paths from inputs to outputs.

Decomposition:
- Shared package pipeline_pkg:
  - OPCODE_MSB/LSB field constants (31/26).
  - HALT_OP and NOP_INSTR constants, also used by hazard_detection and the decode stage.
  - A typedef for the IF/ID bundle {instruction, pc_plus4, valid}.
- One sub-module: if_id_register. It holds the bundle and has enable, synchronous flush and reset inputs, and is reusable for the other pipeline registers.
- The PC logic, halt tracking and counter stay in fetch_stage.

Test Plan:
- Reset then run: RESET_PC=0, imem returns 32'h2001_0005 at 0 and 32'h2002_0007 at 4, enables=1. After edge 1: D_instruction=32'h2001_0005, D_pc_plus4=4, D_valid=1. After edge 2: D_pc_plus4=8, fetch_count=2.
- Load-use stall: drive pc_enable=0 and ifid_enable=0 for 1 cycle with PC=8. PC stays 8, IF/ID is unchanged, fetch_count is unchanged. The next cycle resumes with PC=12.
- Redirect during stall: enables=0 and redirect_valid=1 with target 32'h0000_0043. PC=32'h40, D_instruction=NOP_INSTR, D_valid=0, fetch_count is unchanged.
- Halt: imem returns 32'hFC00_0000. After the edge, halted=1 and D_instruction=32'hFC00_0000. PC and fetch_count are frozen for 10 cycles even with enables=1. A subsequent redirect to 32'h100 clears halted and sets PC=32'h100.
- Wrap and reset mid-stall: PC=32'hFFFF_FFFC, advance gives PC=0. Then assert reset while enables=0: all outputs return to reset values on that edge.
